cfg_timeout_tracker: RTL and testbench
======================================

Name: cfg_timeout_tracker

Overview:
- Multi-outstanding configuration-request timeout monitor. It snoops the Avalon-MM config-space (cs) port of the PCIe root-port bridge.
- Tracks up to MAX_OUTSTANDING pipelined non-posted requests in issue order and ages the oldest one. On expiry it synthesizes an error completion through the response mux.
- Swallows the orphaned late responses that arrive after a timeout. Exposes timeout statistics and a sticky interrupt to the CSR block.

Parameters:
- ADDR_WIDTH, 14, cs address width
- DATA_WIDTH, 32, cs readdata width
- RESP_WIDTH, 2, Avalon response width
- MAX_OUTSTANDING, 4, tracker depth (power of 2, >=2)
- TIMER_WIDTH, 32, timestamp and timeout width
- LOCAL_ADDR_BIT, 13, address bit; when set, the access is bridge-local and untracked
- ERR_RESP, 2'b10, response code driven on synthesized completions
- TO_RDATA, all-ones, readdata driven on synthesized read completion

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous assert, active-low
- cs_snoop_read_i  in  1  snooped read
- cs_snoop_write_i  in  1  snooped write
- cs_snoop_waitrequest_i  in  1  snooped waitrequest
- cs_snoop_address_i  in  ADDR_WIDTH  snooped address
- cs_snoop_readdatavalid_i  in  1  real read response
- cs_snoop_writerespvalid_i  in  1  real write response
- cs_hold_o  out  1  tracker full; ORed into master waitrequest
- cs_drop_o  out  1  current real response is orphaned; mux must block it
- cs_to_readdatavalid_o  out  1  synthesized read completion
- cs_to_writerespvalid_o  out  1  synthesized write completion
- cs_to_readdata_o  out  DATA_WIDTH  TO_RDATA when readdatavalid, else 0
- cs_to_resp_o  out  RESP_WIDTH  ERR_RESP when valid, else 0
- mux_sel  out  1  selects synthesized response path
- timeout_val_i  in  TIMER_WIDTH  timeout in cycles; 0 disables
- enable_i  in  1  timeout enable
- stat_clear_i  in  1  one-cycle pulse: clear counters and sticky flags
- timeout_count_o  out  16  saturating count of timeouts
- orphan_count_o  out  16  saturating count of dropped late responses
- last_to_addr_o  out  ADDR_WIDTH  address of the most recent timed-out request
- last_to_write_o  out  1  1 if the most recent timeout was a write
- timeout_irq_o  out  1  sticky; set on any timeout
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current occupancy

Behaviour:
- Reset: all outputs, FIFO, timestamp, orphan counter and statistics are 0. Reset mid-flight discards all state with no synthesized responses.
- accept = (read|write) & ~waitrequest_i & ~address[LOCAL_ADDR_BIT] & ~cs_hold_o. It pushes {is_write, addr, ts}, where ts is a free-running TIMER_WIDTH counter that wraps.
- cs_hold_o = (occupancy == MAX_OUTSTANDING). It is combinational from registered state.
- Head age = ts_now - head.ts, computed modulo 2^TIMER_WIDTH; wrap-safe.
- expire = head valid & enable_i & (timeout_val_i != 0) & (age >= timeout_val_i) & no real response this cycle.
- A real response (rdv|wrv) with orphan_cnt == 0 pops the head. With orphan_cnt > 0 it decrements orphan_cnt, asserts cs_drop_o combinationally in the same cycle, and increments orphan_count_o.
- Real response with an empty FIFO and orphan_cnt == 0: ignored. No pop, no underflow.
- On expire, registered (1-cycle latency):
  - pop the head;
  - drive mux_sel=1 and cs_to_readdatavalid_o or cs_to_writerespvalid_o per head.is_write for exactly one cycle;
  - orphan_cnt++ (saturates at MAX_OUTSTANDING);
  - timeout_count_o++;
  - latch last_to_addr_o and last_to_write_o;
  - set timeout_irq_o.
- One expiry at most per cycle. The next head starts aging from its own ts, so an already-stale next entry expires on the following cycle.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Push into a full FIFO cannot occur, since it is gated by cs_hold_o.
- Real response and expire in the same cycle: the real response wins; no synthesized completion.
- stat_clear_i clears the counters, last_to_* and irq. A timeout in the same cycle wins: count becomes 1, irq=1.
- Changing timeout_val_i or enable_i takes effect on the next compare. Disabling does not flush the FIFO.
- Counters saturate at 16'hFFFF.

Decomposition:
- Package cfg_to_pkg holds the entry struct typedef cfg_to_entry_t {is_write, addr, ts}, the ERR_RESP default and the counter width localparam.
- Sub-module cfg_to_fifo: circular buffer of cfg_to_entry_t with push, pop, head, count, full and empty. Registered pointers, async active-low reset.

Test Plan:
- Single read, timeout_val=100, no response: synthesized readdatavalid at cycle 101 after accept, readdata=FFFF_FFFF, resp=2'b10, mux_sel for 1 cycle; timeout_count=1, irq=1.
- 4 writes back-to-back, timeout_val=50, no response: cs_hold_o high after 4th accept; 4 consecutive writerespvalid pulses; then 4 late responses all give cs_drop_o=1 and orphan_count=4.
- Read answered at age 49, timeout_val=50: real response passes, cs_drop_o=0, no timeout. Response exactly on the expiry cycle: real wins, timeout_count stays 0.
- Address bit 13 set with read: not tracked, outstanding_o=0, no timeout ever.
- ts preloaded near 2^32-10, timeout_val=20: expiry occurs exactly 20 cycles after accept across the wrap.
- rstn_i low with 3 outstanding: all outputs 0 immediately; after release, a late response is not dropped (orphan_cnt=0).

Source files
------------

// File: rtl/cfg_to_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cfg_to_pkg                                                 |
// | Brief   : Shared types and constants for the config-request timeout  |
// |           tracker (tracker entry, error response, counter width).    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package cfg_to_pkg;

  // Entry field widths; the tracker's ADDR_WIDTH / TIMER_WIDTH must match.
  localparam int CFG_TO_ADDR_W = 14;
  localparam int CFG_TO_TS_W   = 32;

  // Width of the saturating statistics counters.
  localparam int CFG_TO_CNT_W  = 16;

  // Avalon response code used on synthesized completions (SLVERR).
  localparam logic [1:0] CFG_TO_ERR_RESP = 2'b10;

  // One tracked non-posted request, in issue order.
  typedef struct packed {
    logic                     is_write;
    logic [CFG_TO_ADDR_W-1:0] addr;
    logic [CFG_TO_TS_W-1:0]   ts;
  } cfg_to_entry_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CFG_TO_CNT_W-1:0] cfg_to_sat_inc(
    input logic [CFG_TO_CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_to_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cfg_to_fifo                                                |
// | Brief   : Circular buffer of outstanding config requests. Head is    |
// |           the oldest request; push/pop in one cycle are both taken.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module cfg_to_fifo
  import cfg_to_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  cfg_to_entry_t              entry_i,
  input  logic                       pop_i,
  output cfg_to_entry_t              head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);

  cfg_to_entry_t mem_q [DEPTH];
  cfg_to_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic          w_push, w_pop;

  // Self-protect against overflow/underflow even though the caller gates them.
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i  & ~empty_o;
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy (pointers wrap: DEPTH is 2^n).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = entry_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cfg_timeout_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cfg_timeout_tracker                                        |
// | Brief   : Snoops the PCIe root-port cs port, ages the oldest pending |
// |           non-posted request, synthesizes an error completion on     |
// |           expiry and swallows the orphaned late responses.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module cfg_timeout_tracker
  import cfg_to_pkg::*;
#(
  parameter int                     ADDR_WIDTH      = CFG_TO_ADDR_W,
  parameter int                     DATA_WIDTH      = 32,
  parameter int                     RESP_WIDTH      = 2,
  parameter int                     MAX_OUTSTANDING = 4,
  parameter int                     TIMER_WIDTH     = CFG_TO_TS_W,
  parameter int                     LOCAL_ADDR_BIT  = 13,
  parameter logic [RESP_WIDTH-1:0]  ERR_RESP        = RESP_WIDTH'(CFG_TO_ERR_RESP),
  parameter logic [DATA_WIDTH-1:0]  TO_RDATA        = '1,
  // Reset value of the free-running timestamp.
  parameter logic [TIMER_WIDTH-1:0] TS_INIT         = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 cs_snoop_read_i,
  input  logic                                 cs_snoop_write_i,
  input  logic                                 cs_snoop_waitrequest_i,
  input  logic [ADDR_WIDTH-1:0]                cs_snoop_address_i,
  input  logic                                 cs_snoop_readdatavalid_i,
  input  logic                                 cs_snoop_writerespvalid_i,
  output logic                                 cs_hold_o,
  output logic                                 cs_drop_o,
  output logic                                 cs_to_readdatavalid_o,
  output logic                                 cs_to_writerespvalid_o,
  output logic [DATA_WIDTH-1:0]                cs_to_readdata_o,
  output logic [RESP_WIDTH-1:0]                cs_to_resp_o,
  output logic                                 mux_sel,
  input  logic [TIMER_WIDTH-1:0]               timeout_val_i,
  input  logic                                 enable_i,
  input  logic                                 stat_clear_i,
  output logic [CFG_TO_CNT_W-1:0]              timeout_count_o,
  output logic [CFG_TO_CNT_W-1:0]              orphan_count_o,
  output logic [ADDR_WIDTH-1:0]                last_to_addr_o,
  output logic                                 last_to_write_o,
  output logic                                 timeout_irq_o,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o
);

  localparam int              OW         = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]   ORPHAN_MAX = OW'(MAX_OUTSTANDING);

  cfg_to_entry_t             w_entry, w_head;
  logic [OW-1:0]             w_count;
  logic                      w_full, w_empty;
  logic                      w_accept, w_rsp, w_orphan_rsp, w_expire, w_pop;
  logic [TIMER_WIDTH-1:0]    w_age;

  logic [TIMER_WIDTH-1:0]    ts_q, ts_d;
  logic [OW-1:0]             orphan_q, orphan_d;
  logic                      to_rdv_q, to_rdv_d;
  logic                      to_wrv_q, to_wrv_d;
  logic [CFG_TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CFG_TO_CNT_W-1:0]   orph_cnt_q, orph_cnt_d;
  logic [ADDR_WIDTH-1:0]     last_addr_q, last_addr_d;
  logic                      last_wr_q, last_wr_d;
  logic                      irq_q, irq_d;

  // A request is tracked once the bridge takes it, unless it is bridge-local.
  assign w_accept = (cs_snoop_read_i | cs_snoop_write_i) & ~cs_snoop_waitrequest_i
                  & ~cs_snoop_address_i[LOCAL_ADDR_BIT] & ~cs_hold_o;

  // Real responses either retire the head or are swallowed as orphans.
  assign w_rsp        = cs_snoop_readdatavalid_i | cs_snoop_writerespvalid_i;
  assign w_orphan_rsp = w_rsp & (orphan_q != '0);

  // Modular subtraction keeps the age correct across timestamp wrap.
  assign w_age    = ts_q - TIMER_WIDTH'(w_head.ts);
  assign w_expire = ~w_empty & enable_i & (timeout_val_i != '0)
                  & (w_age >= timeout_val_i) & ~w_rsp;
  assign w_pop    = (w_rsp & ~w_orphan_rsp & ~w_empty) | w_expire;

  // Build the entry pushed on accept.
  always_comb begin
    w_entry          = '0;
    w_entry.is_write = cs_snoop_write_i;
    w_entry.addr     = CFG_TO_ADDR_W'(cs_snoop_address_i);
    w_entry.ts       = CFG_TO_TS_W'(ts_q);
  end

  cfg_to_fifo #(
    .DEPTH   (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_accept),
    .entry_i (w_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Next-state: timestamp, orphan credit, synthesized completion and stats.
  always_comb begin
    ts_d        = ts_q + 1'b1;
    orphan_d    = orphan_q;
    to_rdv_d    = w_expire & ~w_head.is_write;
    to_wrv_d    = w_expire &  w_head.is_write;
    to_cnt_d    = stat_clear_i ? '0 : to_cnt_q;
    orph_cnt_d  = stat_clear_i ? '0 : orph_cnt_q;
    last_addr_d = stat_clear_i ? '0 : last_addr_q;
    last_wr_d   = stat_clear_i ? 1'b0 : last_wr_q;
    irq_d       = stat_clear_i ? 1'b0 : irq_q;

    if (w_orphan_rsp) begin
      orphan_d   = orphan_q - 1'b1;
      orph_cnt_d = cfg_to_sat_inc(orph_cnt_d);
    end

    // Expiry is applied after the clear so a coincident timeout is kept.
    if (w_expire) begin
      if (orphan_q != ORPHAN_MAX) begin
        orphan_d = orphan_q + 1'b1;
      end
      to_cnt_d    = cfg_to_sat_inc(to_cnt_d);
      last_addr_d = ADDR_WIDTH'(w_head.addr);
      last_wr_d   = w_head.is_write;
      irq_d       = 1'b1;
    end
  end

  // State registers, cleared asynchronously; reset never emits a completion.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ts_q        <= TS_INIT;
      orphan_q    <= '0;
      to_rdv_q    <= 1'b0;
      to_wrv_q    <= 1'b0;
      to_cnt_q    <= '0;
      orph_cnt_q  <= '0;
      last_addr_q <= '0;
      last_wr_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      orphan_q    <= orphan_d;
      to_rdv_q    <= to_rdv_d;
      to_wrv_q    <= to_wrv_d;
      to_cnt_q    <= to_cnt_d;
      orph_cnt_q  <= orph_cnt_d;
      last_addr_q <= last_addr_d;
      last_wr_q   <= last_wr_d;
      irq_q       <= irq_d;
    end
  end

  assign cs_hold_o              = w_full;
  assign cs_drop_o              = w_orphan_rsp;
  assign cs_to_readdatavalid_o  = to_rdv_q;
  assign cs_to_writerespvalid_o = to_wrv_q;
  assign mux_sel                = to_rdv_q | to_wrv_q;
  assign cs_to_readdata_o       = to_rdv_q ? TO_RDATA : '0;
  assign cs_to_resp_o           = (to_rdv_q | to_wrv_q) ? ERR_RESP : '0;
  assign timeout_count_o        = to_cnt_q;
  assign orphan_count_o         = orph_cnt_q;
  assign last_to_addr_o         = last_addr_q;
  assign last_to_write_o        = last_wr_q;
  assign timeout_irq_o          = irq_q;
  assign outstanding_o          = w_count;

endmodule
`default_nettype wire

// File: tb/tb_cfg_timeout_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_cfg_timeout_tracker                                     |
// | Brief   : Directed bench for cfg_timeout_tracker with a scoreboard   |
// |           of expected synthesized completions and dropped responses. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_cfg_timeout_tracker;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int TW = 32;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_DROP = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_read = 1'b0, s_write = 1'b0, s_wait = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic          s_rdv = 1'b0, s_wrv = 1'b0;
  logic [TW-1:0] timeout_val = '0;
  logic          enable = 1'b0, stat_clear = 1'b0;

  logic          hold, drop, to_rdv, to_wrv, msel, last_wr, irq;
  logic [DW-1:0] to_rdata;
  logic [1:0]    to_resp;
  logic [15:0]   to_cnt, orph_cnt;
  logic [AW-1:0] last_addr;
  logic [2:0]    outstanding;

  cfg_timeout_tracker #(
    .TS_INIT(32'hFFFF_FFF0)
  ) dut (
    .clk_i                     (clk),
    .rstn_i                    (rstn),
    .cs_snoop_read_i           (s_read),
    .cs_snoop_write_i          (s_write),
    .cs_snoop_waitrequest_i    (s_wait),
    .cs_snoop_address_i        (s_addr),
    .cs_snoop_readdatavalid_i  (s_rdv),
    .cs_snoop_writerespvalid_i (s_wrv),
    .cs_hold_o                 (hold),
    .cs_drop_o                 (drop),
    .cs_to_readdatavalid_o     (to_rdv),
    .cs_to_writerespvalid_o    (to_wrv),
    .cs_to_readdata_o          (to_rdata),
    .cs_to_resp_o              (to_resp),
    .mux_sel                   (msel),
    .timeout_val_i             (timeout_val),
    .enable_i                  (enable),
    .stat_clear_i              (stat_clear),
    .timeout_count_o           (to_cnt),
    .orphan_count_o            (orph_cnt),
    .last_to_addr_o            (last_addr),
    .last_to_write_o           (last_wr),
    .timeout_irq_o             (irq),
    .outstanding_o             (outstanding)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    int            at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [AW-1:0] a, input int at);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Monitor: consume one expected entry per observed output event.
  task automatic mon_one(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_output", {61'd0, to_rdv, to_wrv, drop}, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
      if (kind != K_DROP) begin
        chk("to_readdata", to_rdata, (kind == K_RD) ? 64'hFFFF_FFFF : 64'd0);
        chk("to_resp", to_resp, 64'd2);
        chk("to_mux_sel", msel, 64'd1);
        chk("to_last_addr", last_addr, e.addr);
        chk("to_last_write", last_wr, (kind == K_WR) ? 64'd1 : 64'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (to_rdv || to_wrv) mon_one(to_wrv ? K_WR : K_RD);
      if (drop) mon_one(K_DROP);
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input bit rdv, input bit wrv, input bit clr, output int c);
    @(posedge clk);
    #1;
    s_read = rd; s_write = wr; s_addr = a;
    s_rdv = rdv; s_wrv = wrv; stat_clear = clr;
    c = cyc;
  endtask

  task automatic idle(input int n);
    int c;
    repeat (n) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, c);
  endtask

  task automatic late_rsp_drop(input bit wr);
    int c;
    step(1'b0, 1'b0, '0, !wr, wr, 1'b0, c);
    expect_ev(K_DROP, '0, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_hold", hold, 0);
    chk("rst_to_count", to_cnt, 0);
    chk("rst_orphan_count", orph_cnt, 0);
    chk("rst_irq", irq, 0);
    chk("rst_mux_sel", msel, 0);
    chk("rst_to_resp", to_resp, 0);
    chk("rst_to_rdata", to_rdata, 0);
    rstn = 1'b1;
    enable = 1'b1;

    // Timestamp wrap: ts starts at FFFF_FFF0, so this read ages across zero
    timeout_val = 20;
    idle(4);
    step(1'b1, 1'b0, 14'h00AB, 1'b0, 1'b0, 1'b0, c);
    expect_ev(K_RD, 14'h00AB, c + 21);
    idle(25);
    chk("wrap_to_count", to_cnt, 1);
    chk("wrap_irq", irq, 1);
    chk("wrap_outstanding", outstanding, 0);
    late_rsp_drop(1'b0);
    idle(2);
    chk("wrap_orphan_count", orph_cnt, 1);

    // Single read, timeout 100
    timeout_val = 100;
    step(1'b1, 1'b0, 14'h1234, 1'b0, 1'b0, 1'b0, c);
    expect_ev(K_RD, 14'h1234, c + 101);
    idle(104);
    chk("rd100_to_count", to_cnt, 2);
    chk("rd100_mux_sel_after", msel, 0);
    chk("rd100_rdata_after", to_rdata, 0);
    late_rsp_drop(1'b0);

    // Four back-to-back writes, timeout 50
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, c);
    idle(1);
    chk("clr_to_count", to_cnt, 0);
    chk("clr_orphan_count", orph_cnt, 0);
    chk("clr_irq", irq, 0);
    timeout_val = 50;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 14'h0100 + 14'(i), 1'b0, 1'b0, 1'b0, c);
      expect_ev(K_WR, 14'h0100 + 14'(i), c + 51);
    end
    step(1'b0, 1'b1, 14'h0104, 1'b0, 1'b0, 1'b0, c);
    chk("full_hold", hold, 1);
    chk("full_outstanding", outstanding, 4);
    idle(1);
    chk("held_write_not_taken", outstanding, 4);
    idle(55);
    chk("wr4_outstanding", outstanding, 0);
    chk("wr4_hold", hold, 0);
    chk("wr4_to_count", to_cnt, 4);
    for (int i = 0; i < 4; i++) late_rsp_drop(1'b1);
    idle(2);
    chk("wr4_orphan_count", orph_cnt, 4);

    // stat_clear in the same cycle as an expiry: the timeout is kept
    timeout_val = 10;
    step(1'b1, 1'b0, 14'h0055, 1'b0, 1'b0, 1'b0, c);
    expect_ev(K_RD, 14'h0055, c + 11);
    idle(9);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, c0);
    idle(3);
    chk("clr_vs_to_count", to_cnt, 1);
    chk("clr_vs_to_irq", irq, 1);
    chk("clr_vs_to_orphan_count", orph_cnt, 0);
    late_rsp_drop(1'b0);

    // Response at age 49 and exactly on the expiry cycle
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, c);
    timeout_val = 50;
    step(1'b1, 1'b0, 14'h0010, 1'b0, 1'b0, 1'b0, c);
    idle(48);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, c);
    #1;
    chk("age49_drop", drop, 0);
    idle(60);
    chk("age49_to_count", to_cnt, 0);
    chk("age49_outstanding", outstanding, 0);
    step(1'b1, 1'b0, 14'h0011, 1'b0, 1'b0, 1'b0, c);
    idle(49);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, c);
    #1;
    chk("age50_drop", drop, 0);
    idle(60);
    chk("age50_to_count", to_cnt, 0);
    chk("age50_irq", irq, 0);
    chk("age50_outstanding", outstanding, 0);

    // Disabled aging, simultaneous push+pop, then re-enable on a stale head
    enable = 1'b0;
    step(1'b1, 1'b0, 14'h0020, 1'b0, 1'b0, 1'b0, c);
    idle(5);
    step(1'b1, 1'b0, 14'h0021, 1'b1, 1'b0, 1'b0, c);
    idle(60);
    chk("disabled_outstanding", outstanding, 1);
    chk("disabled_to_count", to_cnt, 0);
    enable = 1'b1;
    expect_ev(K_RD, 14'h0021, cyc + 1);
    idle(3);
    chk("reenable_to_count", to_cnt, 1);
    chk("reenable_outstanding", outstanding, 0);
    late_rsp_drop(1'b0);

    // Bridge-local access is never tracked
    step(1'b1, 1'b0, 14'h2010, 1'b0, 1'b0, 1'b0, c);
    idle(1);
    chk("local_outstanding", outstanding, 0);
    idle(60);
    chk("local_to_count", to_cnt, 1);

    // Reset with three outstanding and one orphan credit pending
    timeout_val = 30;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 14'h0030 + 14'(i), 1'b0, 1'b0, 1'b0, c);
      if (i == 0) begin
        c0 = c;
        expect_ev(K_RD, 14'h0030, c + 31);
      end
    end
    idle(28);
    chk("prerst_cycle", cyc, c0 + 31);
    chk("prerst_outstanding", outstanding, 3);
    chk("prerst_irq", irq, 1);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    s_read = 1'b0;
    s_rdv = 1'b1;
    #1;
    chk("rst_mid_outstanding", outstanding, 0);
    chk("rst_mid_hold", hold, 0);
    chk("rst_mid_drop", drop, 0);
    chk("rst_mid_irq", irq, 0);
    chk("rst_mid_to_count", to_cnt, 0);
    chk("rst_mid_orphan_count", orph_cnt, 0);
    chk("rst_mid_mux_sel", msel, 0);
    chk("rst_mid_last_addr", last_addr, 0);
    s_rdv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, c);
    #1;
    chk("postrst_late_drop", drop, 0);
    idle(3);
    chk("postrst_orphan_count", orph_cnt, 0);
    chk("postrst_outstanding", outstanding, 0);
    chk("postrst_to_count", to_cnt, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
